sample_dma_arbiter: RTL and testbench
=====================================

// Module: sample_dma_arbiter
// PURPOSE
//  Samples the 8-bit JA input at a programmable rate and writes the samples into a ring buffer in data RAM.
//  Shares the single RAM port with the processor. The CPU always wins; DMA writes use only cycles the CPU leaves idle.
//  Sits between processor and RAM: it drives the RAM's wEn/addr/dataIn, and the processor's q_dmem path is untouched.
// PARAMETERS
//  DIV        1000   clock cycles per sample tick (>=2)
//  DEPTH      4      pending-sample FIFO entries (power of 2)
//  BASE       12'h800 RAM word address of ring buffer start
//  LEN        256    ring buffer length in words (BASE+LEN <= 4096)
//  IRQ_THRESH 64     samples written per irq pulse (only with SDMA_IRQ_EN)
// PORTS
//  clock       in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high
//  enable      in   1   1 = sampling active
//  clr_ovf     in   1   1-cycle pulse clears overflow
//  sample_in   in   8   JA pins
//  cpu_req     in   1   CPU uses RAM this cycle (load or store)
//  cpu_wren    in   1   CPU write enable
//  cpu_addr    in   12  CPU word address
//  cpu_data    in   32  CPU store data
//  ram_wEn     out  1   to RAM wEn
//  ram_addr    out  12  to RAM addr
//  ram_dataIn  out  32  to RAM dataIn
//  dma_ptr     out  12  ring offset of next DMA write (0..LEN-1)
//  overflow    out  1   sticky: a sample was dropped
//  busy        out  1   FIFO non-empty
//  irq         out  1   (SDMA_IRQ_EN only) 1-cycle pulse
// BEHAVIOUR
//  Reset: counter=0, FIFO empty, seq=0, dma_ptr=0, overflow=0, irq=0. Mux selects the CPU, so ram_wEn=cpu_wren.
//  Rate: when enable=1, the counter counts 0..DIV-1. Tick = (counter==DIV-1). When enable=0, the counter holds at 0 and no tick occurs.
//  Capture on tick: push word {16'h0, seq[7:0], sample_in}, then seq++ (mod 256). Capture is registered, same edge as the tick.
//  FIFO full on tick: drop the sample, set overflow, do not increment seq.
//  Grant (combinational, same cycle):
//   - cpu_req=1: ram_* = cpu_* (wEn=cpu_wren). The DMA does not pop.
//   - cpu_req=0 and FIFO non-empty: ram_wEn=1, ram_addr=BASE+dma_ptr, ram_dataIn=FIFO head. At the clock edge: pop, dma_ptr++.
//   - else: ram_* = cpu_* passthrough with ram_wEn=0.
//  Wrap: dma_ptr==LEN-1 then increments to 0. Older samples are silently overwritten.
//  Simultaneous push and pop: both happen and the occupancy is unchanged. A push into a full FIFO while a pop occurs is NOT a drop (pop first).
//  Simultaneous overflow set and clr_ovf: set wins.
//  Write latency: a sample reaches RAM >=1 cycle after its tick. The FIFO never loses data unless full.
//  enable 1->0: pending FIFO entries still drain. seq and dma_ptr are kept.
//  Reset mid-write: the RAM write in that cycle still occurs (combinational). The FIFO is flushed next edge.
// CONFIGURATION
//  SDMA_IRQ_EN defined: a 16-bit counter counts DMA writes. At IRQ_THRESH, irq=1 for one cycle and the counter returns to 0.
//  SDMA_IRQ_EN undefined: no irq port, no counter. All other behaviour is identical.
// STRUCTURE
//  Package sdma_pkg: RAM address width (12), data width (32), sample word layout localparams.
//  Sub-module sdma_fifo (sync FIFO with push/pop/full/empty, first-word-fall-through head).
//  Top holds the rate counter, seq, ptr, overflow, grant mux and irq logic.
// TESTING
//  1. DIV=4, enable=1, cpu_req=0, sample_in=8'hA5.
//     -> The first write occurs 1 cycle after the tick at cycle 3: addr 12'h800, data 32'h0000_00A5. The next data is 32'h0000_01A5.
//  2. cpu_req=1 with cpu_wren=1, addr 12'h010, data 32'hDEAD_BEEF, during pending samples.
//     -> The RAM sees the CPU write. busy stays 1 and dma_ptr is unchanged until cpu_req=0.
//  3. cpu_req held 1 for 5*DIV cycles, DEPTH=4.
//     -> 4 samples are queued, the 5th is dropped, overflow=1, seq=4. On release, 4 writes occur back-to-back.
//  4. LEN=4, 6 samples.
//     -> Writes go to 800,801,802,803,800,801. dma_ptr ends at 2.
//  5. Reset asserted with 2 queued.
//     -> Next cycle busy=0, dma_ptr=0, overflow=0, and ram_wEn follows cpu_wren.
//  6. SDMA_IRQ_EN, IRQ_THRESH=3.
//     -> irq pulses once after the 3rd and 6th DMA writes.

Source files
------------

// File: rtl/sdma_pkg.sv
// Shared widths and the layout of a captured sample word.
package sdma_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 8;
    localparam int SEQ_W    = 8;
    localparam int PAD_W    = DATA_W - SEQ_W - SAMPLE_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic [PAD_W-1:0]    pad;
        logic [SEQ_W-1:0]    seq;
        logic [SAMPLE_W-1:0] sample;
    } sample_word_t;

    function automatic data_t make_word(input logic [SEQ_W-1:0] seq,
                                        input logic [SAMPLE_W-1:0] sample);
        sample_word_t w;
        w.pad    = '0;
        w.seq    = seq;
        w.sample = sample;
        return data_t'(w);
    endfunction

endpackage

// File: rtl/sdma_if.sv
// Shared RAM port bundle: CPU request side in, single RAM write/address port out.
interface sdma_if;
    import sdma_pkg::*;

    logic  cpu_req;
    logic  cpu_wren;
    addr_t cpu_addr;
    data_t cpu_data;
    logic  ram_wEn;
    addr_t ram_addr;
    data_t ram_dataIn;

    // master: the arbiter, which owns the RAM port
    modport master (
        input  cpu_req, cpu_wren, cpu_addr, cpu_data,
        output ram_wEn, ram_addr, ram_dataIn
    );

    modport slave (
        output cpu_req, cpu_wren, cpu_addr, cpu_data,
        input  ram_wEn, ram_addr, ram_dataIn
    );

endinterface

// File: rtl/sdma_fifo.sv
// Synchronous FIFO with first-word-fall-through head; DEPTH must be a power of 2 (>=2).
// Latency: pushed word visible at head the cycle after the push edge.
// Backpressure: push into a full FIFO is ignored unless a pop happens on the same edge.
module sdma_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/sample_dma_arbiter.sv
// Samples sample_in every DIV cycles into a ring buffer in RAM, using only RAM cycles the CPU leaves idle.
// Latency: a sample is written >=1 cycle after its tick; grant mux is combinational. Optional irq: SDMA_IRQ_EN.
// Backpressure: CPU always wins; a tick with the FIFO full (and no pop) drops the sample and sets overflow.
module sample_dma_arbiter
    import sdma_pkg::*;
#(
    parameter int    DIV   = 1000,
    parameter int    DEPTH = 4,
    parameter addr_t BASE  = 12'h800,
    parameter int    LEN   = 256
`ifdef SDMA_IRQ_EN
    , parameter int  IRQ_THRESH = 64
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clr_ovf,
    input  logic [SAMPLE_W-1:0] sample_in,
    sdma_if.master              bus,
    output addr_t               dma_ptr,
    output logic                overflow,
    output logic                busy
`ifdef SDMA_IRQ_EN
    , output logic              irq
`endif
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    addr_t            ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             tick, dma_go, push, drop;
    logic             fifo_full, fifo_empty;
    data_t            fifo_head;

    always_comb begin
        tick   = enable && (cnt_q == CNT_W'(DIV - 1));
        dma_go = !bus.cpu_req && !fifo_empty;
        // A pop on the same edge frees a slot, so a full FIFO only drops when idle.
        push   = tick && (!fifo_full || dma_go);
        drop   = tick && fifo_full && !dma_go;
        cnt_d  = (enable && !tick) ? cnt_q + 1'b1 : '0;
        seq_d  = push ? seq_q + 1'b1 : seq_q;
        ptr_d  = ptr_q;
        if (dma_go) ptr_d = (ptr_q == ADDR_W'(LEN - 1)) ? '0 : ptr_q + 1'b1;
        ovf_d  = drop | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            seq_q <= '0;
            ptr_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            seq_q <= seq_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
        end
    end

    sdma_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (make_word(seq_q, sample_in)),
        .pop      (dma_go),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Grant depends only on current state, so a write in a reset cycle still goes out.
    always_comb begin
        bus.ram_wEn    = 1'b0;
        bus.ram_addr   = bus.cpu_addr;
        bus.ram_dataIn = bus.cpu_data;
        if (bus.cpu_req) begin
            bus.ram_wEn = bus.cpu_wren;
        end else if (dma_go) begin
            bus.ram_wEn    = 1'b1;
            bus.ram_addr   = BASE + ptr_q;
            bus.ram_dataIn = fifo_head;
        end
    end

    assign dma_ptr  = ptr_q;
    assign overflow = ovf_q;
    assign busy     = !fifo_empty;

`ifdef SDMA_IRQ_EN
    logic [15:0] wcnt_q, wcnt_d;
    logic        irq_q, irq_d;

    always_comb begin
        wcnt_d = wcnt_q;
        irq_d  = 1'b0;
        if (dma_go) begin
            if (wcnt_q == 16'(IRQ_THRESH - 1)) begin
                wcnt_d = '0;
                irq_d  = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_sample_dma_arbiter.sv
// Bench for sample_dma_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_sample_dma_arbiter;
    import sdma_pkg::*;

    localparam int          DIV        = 4;
    localparam int          DEPTH      = 4;
    localparam int          LEN        = 4;
    localparam int          IRQ_THRESH = 3;
    localparam logic [11:0] BASE       = 12'h800;

    logic        clock = 1'b0;
    logic        reset, enable, clr_ovf;
    logic [7:0]  sample_in;
    logic [11:0] dma_ptr;
    logic        overflow, busy;
`ifdef SDMA_IRQ_EN
    logic        irq;
`endif

    sdma_if bus();

    sample_dma_arbiter #(
        .DIV(DIV), .DEPTH(DEPTH), .BASE(BASE), .LEN(LEN)
`ifdef SDMA_IRQ_EN
        , .IRQ_THRESH(IRQ_THRESH)
`endif
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clr_ovf(clr_ovf),
        .sample_in(sample_in), .bus(bus), .dma_ptr(dma_ptr),
        .overflow(overflow), .busy(busy)
`ifdef SDMA_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: pending samples as a queue, ring offset, sticky flag.
    int          m_run  = 0;
    int          m_seq  = 0;
    int          m_ptr  = 0;
    int          m_wcnt = 0;
    bit          m_ovf  = 0;
    bit          m_irq  = 0;
    logic [31:0] m_q[$];

    task automatic model_edge();
        bit pop, tick, drop;
        if (reset) begin
            m_run = 0; m_seq = 0; m_ptr = 0; m_wcnt = 0; m_ovf = 0; m_irq = 0;
            m_q.delete();
            return;
        end
        pop  = !bus.cpu_req && (m_q.size() != 0);
        if (enable) m_run++; else m_run = 0;
        tick = enable && (m_run % DIV == 0);
        m_irq = 0;
        if (pop) begin
            m_q.delete(0);
            m_ptr = (m_ptr + 1) % LEN;
            m_wcnt++;
            if (m_wcnt == IRQ_THRESH) begin m_wcnt = 0; m_irq = 1; end
        end
        drop = 0;
        if (tick) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({16'h0, 8'(m_seq), sample_in});
                m_seq = (m_seq + 1) % 256;
            end else begin
                drop = 1;
            end
        end
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    // Called at the negedge: advance the model across the coming edge, land just after it.
    task automatic finish_cycle();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; clr_ovf = 0; sample_in = 8'h00;
        bus.cpu_req = 0; bus.cpu_wren = 0; bus.cpu_addr = '0; bus.cpu_data = '0;
        repeat (2) begin @(negedge clock); finish_cycle(); end
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; clr_ovf = 0; sample_in = 8'h5A;
        bus.cpu_req = 1; bus.cpu_wren = 1; bus.cpu_addr = 12'h123; bus.cpu_data = 32'h1234_5678;
        repeat (3) begin @(negedge clock); finish_cycle(); end
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (dma_ptr !== 12'h000) begin bad++; $display("FAIL reset_ptr: got %h want 000", dma_ptr); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        total++;
        if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== {1'b1, 12'h123, 32'h1234_5678}) begin
            bad++; $display("FAIL reset_cpu_pass: got %b %h %h want 1 123 12345678",
                            bus.ram_wEn, bus.ram_addr, bus.ram_dataIn);
        end
        finish_cycle();
        bus.cpu_wren = 0;
        @(negedge clock);
        total++; if (bus.ram_wEn !== 1'b0) begin bad++; $display("FAIL reset_cpu_rd: got %b want 0", bus.ram_wEn); end
`ifdef SDMA_IRQ_EN
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
        finish_cycle();
        reset = 0;
    endtask

    task automatic test_first_sample();
        int          wc[$];
        logic [11:0] wa[$];
        logic [31:0] wd[$];
        do_reset();
        enable = 1; sample_in = 8'hA5; bus.cpu_req = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (bus.ram_wEn === 1'b1) begin
                wc.push_back(c); wa.push_back(bus.ram_addr); wd.push_back(bus.ram_dataIn);
            end
            finish_cycle();
        end
        total++;
        if (wc.size() != 2) begin
            bad++; $display("FAIL first_count: got %0d writes want 2", wc.size());
        end else begin
            total++; if (wc[0] != 4) begin bad++; $display("FAIL first_cycle: got %0d want 4", wc[0]); end
            total++; if (wa[0] !== 12'h800) begin bad++; $display("FAIL first_addr: got %h want 800", wa[0]); end
            total++; if (wd[0] !== 32'h0000_00A5) begin bad++; $display("FAIL first_data: got %h want 000000a5", wd[0]); end
            total++; if (wd[1] !== 32'h0000_01A5) begin bad++; $display("FAIL second_data: got %h want 000001a5", wd[1]); end
            total++; if (wa[1] !== 12'h801) begin bad++; $display("FAIL second_addr: got %h want 801", wa[1]); end
        end
    endtask

    task automatic test_cpu_priority();
        do_reset();
        enable = 1; sample_in = 8'h3C;
        bus.cpu_req = 1; bus.cpu_wren = 1; bus.cpu_addr = 12'h010; bus.cpu_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            if (c >= 4) begin
                total++;
                if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== {1'b1, 12'h010, 32'hDEAD_BEEF}) begin
                    bad++; $display("FAIL cpu_wins c%0d: got %b %h %h want 1 010 deadbeef",
                                    c, bus.ram_wEn, bus.ram_addr, bus.ram_dataIn);
                end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL cpu_busy c%0d: got %b want 1", c, busy); end
                total++; if (dma_ptr !== 12'h000) begin bad++; $display("FAIL cpu_ptr c%0d: got %h want 000", c, dma_ptr); end
            end
            finish_cycle();
        end
        bus.cpu_req = 0;
        @(negedge clock);
        total++;
        if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== {1'b1, 12'h800, 32'h0000_003C}) begin
            bad++; $display("FAIL release_write: got %b %h %h want 1 800 0000003c",
                            bus.ram_wEn, bus.ram_addr, bus.ram_dataIn);
        end
        finish_cycle();
        @(negedge clock);
        total++; if (dma_ptr !== 12'h001) begin bad++; $display("FAIL release_ptr: got %h want 001", dma_ptr); end
        total++;
        if ({bus.ram_addr, bus.ram_dataIn} !== {12'h801, 32'h0000_013C}) begin
            bad++; $display("FAIL release_next: got %h %h want 801 0000013c", bus.ram_addr, bus.ram_dataIn);
        end
        finish_cycle();
    endtask

    task automatic test_overflow();
        logic [7:0]  s;
        logic [11:0] ea;
        logic [31:0] ed;
        do_reset();
        s = 8'($urandom);
        enable = 1; sample_in = s;
        bus.cpu_req = 1; bus.cpu_wren = 0; bus.cpu_addr = 12'($urandom); bus.cpu_data = $urandom;
        repeat (5 * DIV) begin @(negedge clock); finish_cycle(); end
        bus.cpu_req = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 0) begin
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_busy: got %b want 1", busy); end
            end
            ea = BASE + 12'(i % LEN);
            ed = {16'h0, 8'(i), s};
            total++;
            if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== {1'b1, ea, ed}) begin
                bad++; $display("FAIL drain%0d: got %b %h %h want 1 %h %h",
                                i, bus.ram_wEn, bus.ram_addr, bus.ram_dataIn, ea, ed);
            end
            finish_cycle();
        end
        clr_ovf = 1;
        @(negedge clock); finish_cycle();
        clr_ovf = 0;
        @(negedge clock);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        finish_cycle();
    endtask

    task automatic test_wrap();
        logic [11:0] wa[$];
        logic [11:0] exp_a[6];
        exp_a = '{12'h800, 12'h801, 12'h802, 12'h803, 12'h800, 12'h801};
        do_reset();
        enable = 1; bus.cpu_req = 0; sample_in = 8'($urandom);
        repeat (6 * DIV + 1) begin
            @(negedge clock);
            if (bus.ram_wEn === 1'b1) wa.push_back(bus.ram_addr);
            finish_cycle();
        end
        @(negedge clock);
        total++; if (dma_ptr !== 12'h002) begin bad++; $display("FAIL wrap_ptr: got %h want 002", dma_ptr); end
        finish_cycle();
        total++;
        if (wa.size() != 6) begin
            bad++; $display("FAIL wrap_count: got %0d want 6", wa.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (wa[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, wa[i], exp_a[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1; sample_in = 8'h77; bus.cpu_req = 0; bus.cpu_wren = 0;
        repeat (10) begin @(negedge clock); finish_cycle(); end
        bus.cpu_req = 1;
        repeat (5 * DIV) begin @(negedge clock); finish_cycle(); end
        reset = 1; bus.cpu_req = 0;
        @(negedge clock);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL mid_pre_ovf: got %b want 1", overflow); end
        total++; if (dma_ptr !== 12'h002) begin bad++; $display("FAIL mid_pre_ptr: got %h want 002", dma_ptr); end
        total++;
        if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== {1'b1, 12'h802, 32'h0000_0277}) begin
            bad++; $display("FAIL mid_write: got %b %h %h want 1 802 00000277",
                            bus.ram_wEn, bus.ram_addr, bus.ram_dataIn);
        end
        finish_cycle();
        reset = 0; bus.cpu_req = 1; bus.cpu_wren = 1;
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (dma_ptr !== 12'h000) begin bad++; $display("FAIL mid_ptr: got %h want 000", dma_ptr); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
        total++; if (bus.ram_wEn !== 1'b1) begin bad++; $display("FAIL mid_wen: got %b want 1", bus.ram_wEn); end
        finish_cycle();
    endtask

`ifdef SDMA_IRQ_EN
    task automatic test_irq();
        int pulses[$];
        do_reset();
        enable = 1; bus.cpu_req = 0; sample_in = 8'h11;
        for (int c = 0; c < 6 * DIV + 3; c++) begin
            @(negedge clock);
            if (irq === 1'b1) pulses.push_back(c);
            finish_cycle();
        end
        total++;
        if (pulses.size() != 2) begin
            bad++; $display("FAIL irq_count: got %0d want 2", pulses.size());
        end else begin
            total++; if (pulses[0] != 13) begin bad++; $display("FAIL irq_first: got %0d want 13", pulses[0]); end
            total++; if (pulses[1] != 25) begin bad++; $display("FAIL irq_second: got %0d want 25", pulses[1]); end
        end
    endtask
`endif

    task automatic test_random();
        bit          heavy;
        logic [44:0] exp_ram;
        do_reset();
        heavy = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 16 == 0) heavy = 1'($urandom_range(0, 1));
            reset         = ($urandom_range(0, 299) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            clr_ovf       = ($urandom_range(0, 19) == 0);
            bus.cpu_req   = heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
            bus.cpu_wren  = 1'($urandom);
            bus.cpu_addr  = 12'($urandom);
            bus.cpu_data  = $urandom;
            sample_in     = 8'($urandom);
            @(negedge clock);
            if (bus.cpu_req)
                exp_ram = {bus.cpu_wren, bus.cpu_addr, bus.cpu_data};
            else if (m_q.size() != 0)
                exp_ram = {1'b1, BASE + 12'(m_ptr), m_q[0]};
            else
                exp_ram = {1'b0, bus.cpu_addr, bus.cpu_data};
            total++;
            if ({bus.ram_wEn, bus.ram_addr, bus.ram_dataIn} !== exp_ram) begin
                bad++; $display("FAIL rnd_ram c%0d: got %b %h %h want %b %h %h", c,
                                bus.ram_wEn, bus.ram_addr, bus.ram_dataIn,
                                exp_ram[44], exp_ram[43:32], exp_ram[31:0]);
            end
            total++; if (dma_ptr !== 12'(m_ptr)) begin bad++; $display("FAIL rnd_ptr c%0d: got %h want %h", c, dma_ptr, 12'(m_ptr)); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, overflow, m_ovf); end
            total++; if (busy !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_q.size() != 0); end
`ifdef SDMA_IRQ_EN
            total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq c%0d: got %b want %b", c, irq, m_irq); end
`endif
            finish_cycle();
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; enable = 0; clr_ovf = 0; sample_in = 8'h00;
        bus.cpu_req = 0; bus.cpu_wren = 0; bus.cpu_addr = '0; bus.cpu_data = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_first_sample();
        test_cpu_priority();
        test_overflow();
        test_wrap();
        test_reset_mid();
`ifdef SDMA_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
